ethii_tx_arbiter: RTL and testbench

- Packet-level round-robin arbiter between NUM_SRC EthII transmit sources, e.g. source 0 = ARP, source 1 = IPv4, with room for later ICMP/raw sources.
- Each source presents a MAC header handshake plus an AXI-Stream-style 32-bit payload.
- The block grants one source for one complete packet (header, then payload up to tlast) and forwards it unchanged to the EthII packer.
- Sits between the protocol engines and the packer; it replaces the fixed mux and adds fairness and per-source packet counters.

---
 rtl/ethii_tx_arbiter.sv | 166 ++++++++++++++++
 tb/tb_ethii_tx_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ethii_tx_arbiter.sv
// Packet-level round-robin arbiter in front of the EthII packer: one source owns
// the header and payload path from header handshake through its tlast beat.
module ethii_tx_arbiter #(
    parameter int NUM_SRC = 2,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [48*NUM_SRC-1:0]         src_mac_dest_i,
    input  logic [48*NUM_SRC-1:0]         src_mac_src_i,
    input  logic [16*NUM_SRC-1:0]         src_mac_type_i,
    input  logic [NUM_SRC-1:0]            src_mac_vld_i,
    output logic [NUM_SRC-1:0]            src_mac_rdy_o,
    input  logic [DATA_W*NUM_SRC-1:0]     src_tdata_i,
    input  logic [(DATA_W/8)*NUM_SRC-1:0] src_tkeep_i,
    input  logic [NUM_SRC-1:0]            src_tvld_i,
    input  logic [NUM_SRC-1:0]            src_tlast_i,
    output logic [NUM_SRC-1:0]            src_trdy_o,
    output logic [47:0]                   hdr_mac_dest_o,
    output logic [47:0]                   hdr_mac_src_o,
    output logic [15:0]                   hdr_mac_type_o,
    output logic                          hdr_mac_vld_o,
    input  logic                          hdr_mac_rdy_i,
    output logic [DATA_W-1:0]             user_tdata_o,
    output logic [DATA_W/8-1:0]           user_tkeep_o,
    output logic                          user_tvld_o,
    output logic                          user_tlast_o,
    input  logic                          user_trdy_i,
    output logic [NUM_SRC-1:0]            grant_o,
    output logic                          busy_o,
    output logic [CNT_W*NUM_SRC-1:0]      pkt_cnt_o
);
    localparam int KEEP_W = DATA_W / 8;
    localparam int IDX_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [NUM_SRC-1:0] GRANT_ONE = {{(NUM_SRC-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2
    } state_t;

    state_t             state_r;
    logic [NUM_SRC-1:0] grant_r;
    logic [IDX_W-1:0]   gidx_r;
    logic [IDX_W-1:0]   rr_ptr_r;
    logic               busy_r;
    logic [CNT_W-1:0]   cnt_r [NUM_SRC];

    logic [IDX_W-1:0]   pick_s;
    logic               found_s;
    logic [47:0]        sel_dest_s;
    logic [47:0]        sel_src_s;
    logic [15:0]        sel_type_s;
    logic [DATA_W-1:0]  sel_tdata_s;
    logic [KEEP_W-1:0]  sel_tkeep_s;
    logic               sel_mac_vld_s;
    logic               sel_tvld_s;
    logic               sel_tlast_s;
    logic               in_hdr_s;
    logic               in_payload_s;

    // Round-robin search: first requester at or after rr_ptr+1, wrapping.
    always_comb begin
        pick_s  = '0;
        found_s = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!found_s && src_mac_vld_i[(int'(rr_ptr_r) + 1 + i) % NUM_SRC]) begin
                pick_s  = IDX_W'((int'(rr_ptr_r) + 1 + i) % NUM_SRC);
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // AND-OR mux on the one-hot grant; a zero grant yields all-zero fields.
    always_comb begin
        sel_dest_s    = '0;
        sel_src_s     = '0;
        sel_type_s    = '0;
        sel_tdata_s   = '0;
        sel_tkeep_s   = '0;
        sel_mac_vld_s = 1'b0;
        sel_tvld_s    = 1'b0;
        sel_tlast_s   = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            sel_dest_s    = sel_dest_s  | (src_mac_dest_i[48*k +: 48] & {48{grant_r[k]}});
            sel_src_s     = sel_src_s   | (src_mac_src_i[48*k +: 48]  & {48{grant_r[k]}});
            sel_type_s    = sel_type_s  | (src_mac_type_i[16*k +: 16] & {16{grant_r[k]}});
            sel_tdata_s   = sel_tdata_s | (src_tdata_i[DATA_W*k +: DATA_W] & {DATA_W{grant_r[k]}});
            sel_tkeep_s   = sel_tkeep_s | (src_tkeep_i[KEEP_W*k +: KEEP_W] & {KEEP_W{grant_r[k]}});
            sel_mac_vld_s = sel_mac_vld_s | (src_mac_vld_i[k] & grant_r[k]);
            sel_tvld_s    = sel_tvld_s    | (src_tvld_i[k]    & grant_r[k]);
            sel_tlast_s   = sel_tlast_s   | (src_tlast_i[k]   & grant_r[k]);
        end
    end

    assign in_hdr_s     = (state_r == ST_HDR);
    assign in_payload_s = (state_r == ST_PAYLOAD);

    assign hdr_mac_dest_o = sel_dest_s;
    assign hdr_mac_src_o  = sel_src_s;
    assign hdr_mac_type_o = sel_type_s;
    assign hdr_mac_vld_o  = in_hdr_s & sel_mac_vld_s;
    assign src_mac_rdy_o  = grant_r & {NUM_SRC{in_hdr_s & hdr_mac_rdy_i}};

    // Payload only flows once the header is through; early beats are held off.
    assign user_tdata_o = sel_tdata_s & {DATA_W{in_payload_s}};
    assign user_tkeep_o = sel_tkeep_s & {KEEP_W{in_payload_s}};
    assign user_tvld_o  = in_payload_s & sel_tvld_s;
    assign user_tlast_o = in_payload_s & sel_tlast_s;
    assign src_trdy_o   = grant_r & {NUM_SRC{in_payload_s & user_trdy_i}};

    assign grant_o = grant_r;
    assign busy_o  = busy_r;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_cnt
        assign pkt_cnt_o[CNT_W*k +: CNT_W] = cnt_r[k];
    end

    // Packet FSM: grant held from arbitration until the tlast beat is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            grant_r  <= '0;
            gidx_r   <= '0;
            rr_ptr_r <= IDX_W'(NUM_SRC - 1);
            busy_r   <= 1'b0;
            for (int k = 0; k < NUM_SRC; k++) begin
                cnt_r[k] <= '0;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (found_s) begin
                        grant_r <= GRANT_ONE << pick_s;
                        gidx_r  <= pick_s;
                        busy_r  <= 1'b1;
                        state_r <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (sel_mac_vld_s && hdr_mac_rdy_i) begin
                        state_r <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (sel_tvld_s && user_trdy_i && sel_tlast_s) begin
                        cnt_r[gidx_r] <= cnt_r[gidx_r] + CNT_W'(1);
                        rr_ptr_r      <= gidx_r;
                        grant_r       <= '0;
                        busy_r        <= 1'b0;
                        state_r       <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    grant_r <= '0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ethii_tx_arbiter.sv
// Directed bench for ethii_tx_arbiter: two sources, 4-bit packet counters so the
// counter wrap can be reached quickly.
module tb_ethii_tx_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [95:0] mac_dest;
    logic [95:0] mac_src;
    logic [31:0] mac_type;
    logic [1:0]  mac_vld;
    logic [1:0]  mac_rdy;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic [1:0]  tvld;
    logic [1:0]  tlast;
    logic [1:0]  src_trdy;
    logic [47:0] hdr_dest;
    logic [47:0] hdr_src;
    logic [15:0] hdr_type;
    logic        hdr_vld;
    logic        hdr_rdy;
    logic [31:0] user_tdata;
    logic [3:0]  user_tkeep;
    logic        user_tvld;
    logic        user_tlast;
    logic        user_trdy;
    logic [1:0]  grant;
    logic        busy;
    logic [7:0]  pkt_cnt;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [3:0]  exp_cnt [2];

    ethii_tx_arbiter #(.NUM_SRC(2), .DATA_W(32), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .src_mac_dest_i(mac_dest), .src_mac_src_i(mac_src), .src_mac_type_i(mac_type),
        .src_mac_vld_i(mac_vld), .src_mac_rdy_o(mac_rdy),
        .src_tdata_i(tdata), .src_tkeep_i(tkeep), .src_tvld_i(tvld), .src_tlast_i(tlast),
        .src_trdy_o(src_trdy),
        .hdr_mac_dest_o(hdr_dest), .hdr_mac_src_o(hdr_src), .hdr_mac_type_o(hdr_type),
        .hdr_mac_vld_o(hdr_vld), .hdr_mac_rdy_i(hdr_rdy),
        .user_tdata_o(user_tdata), .user_tkeep_o(user_tkeep), .user_tvld_o(user_tvld),
        .user_tlast_o(user_tlast), .user_trdy_i(user_trdy),
        .grant_o(grant), .busy_o(busy), .pkt_cnt_o(pkt_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [47:0] exp_dest(input int s);
        return (s == 1) ? 48'hFFFF_FFFF_FFFF : 48'h0200_0000_0010;
    endfunction

    function automatic logic [47:0] exp_srcmac(input int s);
        return (s == 1) ? 48'h0200_0000_00A1 : 48'h0200_0000_00A0;
    endfunction

    function automatic logic [15:0] exp_type(input int s);
        return (s == 1) ? 16'h0800 : 16'h0806;
    endfunction

    function automatic logic [31:0] beat_word(input int s, input int b);
        return {8'(s), 8'(b), 16'hA5C3};
    endfunction

    task automatic do_reset();
        reset     = 1'b1;
        mac_vld   = 2'b00;
        tvld      = 2'b00;
        tlast     = 2'b00;
        hdr_rdy   = 1'b1;
        user_trdy = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset      = 1'b0;
        exp_cnt[0] = 4'd0;
        exp_cnt[1] = 4'd0;
        #1;
        check_value("rst_grant", grant, 2'b00);
        check_value("rst_busy", busy, 1'b0);
        check_value("rst_hdr_vld", hdr_vld, 1'b0);
        check_value("rst_hdr_dest", hdr_dest, 48'h0);
        check_value("rst_tvld", user_tvld, 1'b0);
        check_value("rst_tdata", user_tdata, 32'h0);
        check_value("rst_mac_rdy", mac_rdy, 2'b00);
        check_value("rst_trdy", src_trdy, 2'b00);
        check_value("rst_pkt_cnt", pkt_cnt, 8'h00);
    endtask

    // Called while the arbiter is IDLE; source s is expected to win the next arbitration.
    task automatic serve(input int s, input int nb, input logic [3:0] last_keep,
                         input logic [3:0] rdy_pat, input bit again);
        int         b;
        int         cyc;
        logic [1:0] sel;
        logic       r;
        sel             = 2'b01 << s;
        mac_vld[s]      = 1'b1;
        tvld[s]         = 1'b1;
        tdata[32*s +: 32] = beat_word(s, 0);
        tkeep[4*s +: 4] = (nb == 1) ? last_keep : 4'hF;
        tlast[s]        = (nb == 1);
        hdr_rdy         = 1'b1;
        user_trdy       = 1'b1;
        #1;
        check_value("idle_grant", grant, 2'b00);
        check_value("idle_hdr_vld", hdr_vld, 1'b0);
        check_value("idle_trdy", src_trdy, 2'b00);
        @(posedge clk);
        #2;
        check_value("hdr_grant", grant, sel);
        check_value("hdr_busy", busy, 1'b1);
        check_value("hdr_vld", hdr_vld, 1'b1);
        check_value("hdr_dest", hdr_dest, exp_dest(s));
        check_value("hdr_src", hdr_src, exp_srcmac(s));
        check_value("hdr_type", hdr_type, exp_type(s));
        check_value("hdr_mac_rdy", mac_rdy, sel);
        check_value("hdr_holdoff_trdy", src_trdy, 2'b00);
        check_value("hdr_user_tvld", user_tvld, 1'b0);
        @(posedge clk);
        #2;
        mac_vld[s] = 1'b0;
        b   = 0;
        cyc = 0;
        while (b < nb && cyc < 40) begin
            tdata[32*s +: 32] = beat_word(s, b);
            tkeep[4*s +: 4]   = (b == nb - 1) ? last_keep : 4'hF;
            tlast[s]          = (b == nb - 1);
            tvld[s]           = 1'b1;
            r                 = rdy_pat[cyc % 4];
            user_trdy         = r;
            #1;
            check_value("pl_tvld", user_tvld, 1'b1);
            check_value("pl_tdata", user_tdata, beat_word(s, b));
            check_value("pl_tkeep", user_tkeep, (b == nb - 1) ? last_keep : 4'hF);
            check_value("pl_tlast", user_tlast, (b == nb - 1));
            check_value("pl_trdy", src_trdy, r ? sel : 2'b00);
            check_value("pl_mac_rdy", mac_rdy, 2'b00);
            check_value("pl_grant", grant, sel);
            @(posedge clk);
            #2;
            if (r) b++;
            cyc++;
        end
        if (b < nb) check_value("beat_timeout", b, nb);
        tvld[s]   = 1'b0;
        tlast[s]  = 1'b0;
        user_trdy = 1'b1;
        if (again) mac_vld[s] = 1'b1;
        exp_cnt[s] = exp_cnt[s] + 4'd1;
        #1;
        check_value("end_grant", grant, 2'b00);
        check_value("end_busy", busy, 1'b0);
        check_value("end_tvld", user_tvld, 1'b0);
        check_value("end_pkt_cnt", pkt_cnt[4*s +: 4], exp_cnt[s]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mac_dest = {exp_dest(1), exp_dest(0)};
        mac_src  = {exp_srcmac(1), exp_srcmac(0)};
        mac_type = {exp_type(1), exp_type(0)};
        tdata    = 64'h0;
        tkeep    = 8'h00;

        // Single IPv4 packet of three beats.
        do_reset();
        serve(1, 3, 4'hF, 4'hF, 1'b0);

        // Both sources always requesting: strict alternation starting at source 0.
        do_reset();
        mac_vld = 2'b11;
        for (int i = 0; i < 8; i++) begin
            serve(i % 2, 2, 4'hF, 4'hF, (i < 6));
        end
        check_value("alt_pkt_cnt", pkt_cnt, 8'h44);

        // Packer ready pattern 1,0,0,1 while source 1 streams four beats.
        serve(1, 4, 4'hF, 4'b1001, 1'b0);

        // Single-beat packet with partial keep; afterwards source 1 must win a tie.
        serve(0, 1, 4'b0011, 4'hF, 1'b0);
        mac_vld[0] = 1'b1;
        serve(1, 1, 4'hF, 4'hF, 1'b0);
        serve(0, 2, 4'hF, 4'hF, 1'b0);

        // Reset during beat 2 of a 5-beat packet from source 1.
        mac_vld[1]      = 1'b1;
        tvld[1]         = 1'b1;
        tdata[63:32]    = beat_word(1, 0);
        tkeep[7:4]      = 4'hF;
        tlast[1]        = 1'b0;
        @(posedge clk);
        #2;
        @(posedge clk);
        #2;
        mac_vld[1] = 1'b0;
        @(posedge clk);
        #2;
        tdata[63:32] = beat_word(1, 1);
        #1;
        check_value("mid_beat2", user_tdata, beat_word(1, 1));
        reset = 1'b1;
        @(posedge clk);
        #2;
        reset      = 1'b0;
        tvld[1]    = 1'b0;
        exp_cnt[0] = 4'd0;
        exp_cnt[1] = 4'd0;
        #1;
        check_value("mid_rst_grant", grant, 2'b00);
        check_value("mid_rst_busy", busy, 1'b0);
        check_value("mid_rst_tvld", user_tvld, 1'b0);
        check_value("mid_rst_tlast", user_tlast, 1'b0);
        check_value("mid_rst_trdy", src_trdy, 2'b00);
        check_value("mid_rst_hdr_vld", hdr_vld, 1'b0);
        check_value("mid_rst_pkt_cnt", pkt_cnt, 8'h00);
        mac_vld = 2'b11;
        serve(0, 1, 4'hF, 4'hF, 1'b0);
        serve(1, 1, 4'hF, 4'hF, 1'b0);

        // Seventeen packets from a lone source: the 4-bit counter wraps to 1.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            serve(0, 1, 4'hF, 4'hF, 1'b0);
        end
        check_value("wrap_pkt_cnt0", pkt_cnt[3:0], 4'd1);
        check_value("wrap_pkt_cnt1", pkt_cnt[7:4], 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
